// File: rtl/lfsr_stream_hash.sv
// lfsr_stream_hash: keyed streaming hash. Each accepted DW-bit beat is folded
// into an HW-bit accumulator with a Toeplitz product keyed by a free-running
// LFSR. The digest is the accumulator XOR a per-message one-time-pad LFSR XOR
// the beat count.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   seed_load, seed      reload the key LFSR (honoured in IDLE only)
//   in_valid/in_ready    beat handshake; in_data beat, in_last ends message
//   out_valid/out_ready  digest handshake; out_hash digest
//   busy                 high while a message is in flight or awaiting pickup

// One Toeplitz row: parity of the key window ANDed with the beat.
module lfsr_stream_hash_row #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] key,
  input  logic [DW-1:0] data,
  output logic          bit_o
);
  assign bit_o = ^(key & data);
endmodule

module lfsr_stream_hash #(
  parameter int            DW       = 8,
  parameter int            HW       = 32,
  parameter logic [HW-1:0] POLY     = 32'h8020_0003,
  parameter logic [HW-1:0] OTP_INIT = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          seed_load,
  input  logic [HW-1:0] seed,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [HW-1:0] out_hash,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ABSORB, DONE} state_t;

  state_t        state;
  logic [HW-1:0] l_q, o_q, a_q;
  logic [15:0]   c_q;

  logic          accept, seed_now;
  logic [HW-1:0] seed_g, l_cur, l_nxt, o_nxt, a_nxt, c_ext, t;
  logic [HW+DW-2:0] key;
  logic [15:0]   c_nxt;

  function automatic logic [HW-1:0] step(input logic [HW-1:0] s);
    return {s[HW-2:0], ^(s & POLY)};
  endfunction

  assign in_ready = (state != DONE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign seed_now = seed_load && (state == IDLE);

  // A zero seed would lock the LFSR at zero forever.
  assign seed_g = (seed == '0) ? HW'(1) : seed;

  // A seed loaded alongside a beat takes effect before that beat is keyed.
  assign l_cur = seed_now ? seed_g : l_q;

  // Circular key: row i wraps past the top of L back to its low bits.
  assign key = {l_cur[DW-2:0], l_cur};

  for (genvar i = 0; i < HW; i++) begin : g_row
    lfsr_stream_hash_row #(.DW(DW)) u_row (
      .key  (key[i+DW-1:i]),
      .data (in_data),
      .bit_o(t[i])
    );
  end

  assign l_nxt = step(l_cur);
  assign o_nxt = step(o_q);
  assign a_nxt = a_q ^ t;
  assign c_nxt = (c_q == 16'hFFFF) ? c_q : c_q + 16'd1;
  assign c_ext = HW'(c_nxt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      l_q       <= HW'(1);
      o_q       <= OTP_INIT;
      a_q       <= '0;
      c_q       <= '0;
      out_hash  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, ABSORB: begin
          if (accept) begin
            l_q <= l_nxt;
            o_q <= o_nxt;
            a_q <= a_nxt;
            c_q <= c_nxt;
            if (in_last) begin
              out_hash  <= a_nxt ^ o_nxt ^ c_ext;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ABSORB;
            end
          end else if (seed_now) begin
            l_q <= seed_g;
          end
        end
        DONE: begin
          // L is deliberately kept so the next message sees a new key.
          if (out_ready) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            c_q       <= '0;
            o_q       <= OTP_INIT;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_stream_hash.sv
module tb_lfsr_stream_hash;
  localparam int DW = 8;
  localparam int HW = 32;
  localparam logic [31:0] POLY_C = 32'h8020_0003;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          seed_load = 1'b0;
  logic [HW-1:0] seed = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [HW-1:0] out_hash;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg [64];

  // reference model state
  logic [31:0] m_l, m_o, m_a;
  int          m_c;

  lfsr_stream_hash #(.DW(DW), .HW(HW)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_hash(out_hash), .busy(busy)
  );

  always #5 clk = ~clk;

  // Galois-free Fibonacci shift: shift left, new bit = parity of tapped bits.
  function automatic logic [31:0] mstep(input logic [31:0] s);
    int fb;
    fb = $countones(s & POLY_C) % 2;
    return (s << 1) | 32'(fb);
  endfunction

  task automatic model_reset();
    m_l = 32'd1; m_o = 32'hFFFF_FFFF; m_a = 0; m_c = 0;
  endtask

  task automatic model_seed(input logic [31:0] sd);
    m_l = (sd == 0) ? 32'd1 : sd;
  endtask

  // Hash bit i collects data bit b whenever key bit (i+b) mod HW is set.
  task automatic model_beat(input logic [7:0] d, input bit last, output logic [31:0] h);
    logic [31:0] tv;
    tv = 0;
    for (int i = 0; i < 32; i++)
      for (int b = 0; b < 8; b++)
        if (d[b] && m_l[(i + b) % 32]) tv[i] = ~tv[i];
    m_a = m_a ^ tv;
    m_l = mstep(m_l);
    m_o = mstep(m_o);
    if (m_c < 65535) m_c++;
    h = m_a ^ m_o ^ 32'(m_c);
    if (last) begin m_a = 0; m_c = 0; m_o = 32'hFFFF_FFFF; end
  endtask

  // Send msg[0..n-1]; optional reseed on beat 0, optional ignored seed pulse
  // on beat seed_mid_k, optional idle gaps, and 'hold' cycles of backpressure.
  task automatic run_msg(input string name, input int n, input bit reseed,
                         input logic [31:0] sd, input int seed_mid_k,
                         input bit gaps, input int hold, output logic [31:0] dig);
    logic [31:0] exp, h0;
    exp = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'($urandom); in_data = 8'($urandom); seed_load = 1'b0;
      end
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = msg[k];
      in_last   = (k == n - 1);
      seed_load = (reseed && k == 0) || (k == seed_mid_k);
      seed      = (reseed && k == 0) ? sd : $urandom;
      if (reseed && k == 0) model_seed(sd);
      model_beat(msg[k], k == n - 1, exp);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; seed_load = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid: got %b want 1", name, out_valid); end
    checks++;
    if (out_hash !== exp) begin errors++; $display("FAIL %s out_hash: got %h want %h", name, out_hash, exp); end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s done flags: got in_ready=%b busy=%b want 0 1", name, in_ready, busy);
    end
    h0 = out_hash;
    dig = out_hash;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_hash !== h0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: got v=%b h=%h rdy=%b want 1 %h 0", name, c, out_valid, out_hash, in_ready, h0);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got v=%b rdy=%b busy=%b want 0 1 0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_hash !== 32'h0) begin
      errors++; $display("FAIL reset_state: got v=%b busy=%b h=%h want 0 0 0", out_valid, busy, out_hash);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    model_reset();
  endtask

  task automatic test_vectors();
    logic [31:0] d;
    msg[0] = 8'h00;
    run_msg("vec_zero", 1, 0, 0, -1, 0, 0, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL vec_zero_const: got %h want ffffffff", d); end
    msg[0] = 8'h01;
    run_msg("vec_seed0", 1, 1, 32'h0, -1, 0, 0, d);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL vec_seed0_const: got %h want fffffffe", d); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) msg[k] = 8'($urandom);
      run_msg("random", n, 1'($urandom), $urandom, -1, 1, 0, d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    for (int k = 0; k < 4; k++) msg[k] = 8'($urandom);
    run_msg("backpressure", 4, 0, 0, -1, 0, 5, d);
    // the model consumed nothing during the hold; the next digest proves it
    for (int k = 0; k < 3; k++) msg[k] = 8'($urandom);
    run_msg("after_hold", 3, 0, 0, -1, 0, 0, d);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, unused;
    for (int k = 0; k < 3; k++) msg[k] = 8'($urandom);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = msg[k]; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got v=%b busy=%b want 0 0", out_valid, busy);
    end
    @(negedge clk); reset = 1'b0;
    model_reset();
    run_msg("reset_resend", 3, 0, 0, -1, 0, 0, d);
    unused = d;
  endtask

  task automatic test_seed_absorb();
    logic [31:0] d;
    for (int k = 0; k < 5; k++) msg[k] = 8'($urandom);
    run_msg("seed_absorb", 5, 1, 32'h1234_5678, 2, 0, 0, d);
  endtask

  task automatic test_back_to_back();
    logic [31:0] h1, h2, h3, h4, sd;
    for (int k = 0; k < 4; k++) msg[k] = 8'($urandom);
    msg[0][0] = 1'b1;  // non-zero message so the key actually matters
    run_msg("b2b_first", 4, 0, 0, -1, 0, 0, h1);
    run_msg("b2b_second", 4, 0, 0, -1, 0, 0, h2);
    checks++;
    if (h1 === h2) begin errors++; $display("FAIL b2b_differ: got %h and %h want different", h1, h2); end
    sd = $urandom | 32'h1;
    run_msg("b2b_reseed1", 4, 1, sd, -1, 0, 0, h3);
    run_msg("b2b_reseed2", 4, 1, sd, -1, 1, 0, h4);
    checks++;
    if (h3 !== h4) begin errors++; $display("FAIL b2b_reseed_match: got %h want %h", h4, h3); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_seed_absorb();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
